// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch trigger timing stage: FSM state encoding and default widths.
package glitch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DELAY,
    PULSE,
    GAP
  } state_t;

  localparam int DEF_DELAY_W     = 16;
  localparam int DEF_WIDTH_W     = 8;
  localparam int DEF_REP_W       = 4;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/glitch_trigger_ctrl_sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous pin followed by a rising-edge detector.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              sync_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      sync_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      sync_d <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~sync_d;

endmodule

// File: rtl/glitch_trigger_ctrl.sv
// Decides when the glitch clock is applied: arm, wait for a trigger edge, delay, then
// emit one or more glitch_en pulses separated by gaps.
module glitch_trigger_ctrl
  import glitch_pkg::*;
#(
  parameter int DELAY_W     = DEF_DELAY_W,
  parameter int WIDTH_W     = DEF_WIDTH_W,
  parameter int REP_W       = DEF_REP_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic               abort,
  input  logic               pll_relock,
  input  logic               trigger_in,
  input  logic [DELAY_W-1:0] delay_cycles,
  input  logic [WIDTH_W-1:0] width_cycles,
  input  logic [DELAY_W-1:0] gap_cycles,
  input  logic [REP_W-1:0]   repeat_count,
  output logic               glitch_en,
  output logic               armed,
  output logic               busy,
  output logic               done,
  output logic [REP_W-1:0]   pulse_count
);

  state_t state, next_state;

  logic [DELAY_W-1:0] cfg_delay, cfg_gap;
  logic [WIDTH_W-1:0] cfg_width;
  logic [REP_W-1:0]   cfg_repeat;

  // cnt is shared between the trigger delay and the inter-pulse gap
  logic [DELAY_W-1:0] cnt, cnt_next;
  logic [WIDTH_W-1:0] wcnt, wcnt_next;
  logic [REP_W-1:0]   pulse_count_next;

  logic stop, trig_edge, load_cfg;
  logic glitch_en_next, armed_next, busy_next, done_next;

  assign stop = abort | pll_relock;

  sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_trig_sync (
    .clk   (clk),
    .reset (reset),
    .din   (trigger_in),
    .rise  (trig_edge)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      wcnt        <= '0;
      pulse_count <= '0;
      glitch_en   <= 1'b0;
      armed       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= cnt_next;
      wcnt        <= wcnt_next;
      pulse_count <= pulse_count_next;
      glitch_en   <= glitch_en_next;
      armed       <= armed_next;
      busy        <= busy_next;
      done        <= done_next;
    end
  end

  // NOTE: config is a plain data store qualified by the FSM, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load_cfg) begin
      cfg_delay  <= delay_cycles;
      cfg_width  <= (width_cycles == '0) ? WIDTH_W'(1) : width_cycles;
      cfg_gap    <= (gap_cycles == '0) ? DELAY_W'(1) : gap_cycles;
      cfg_repeat <= (repeat_count == '0) ? REP_W'(1) : repeat_count;
    end
  end

  // NOTE: every signal gets a default before the case so no latch can be inferred.
  always_comb begin
    next_state       = state;
    cnt_next         = cnt;
    wcnt_next        = wcnt;
    pulse_count_next = pulse_count;
    done_next        = 1'b0;
    load_cfg         = 1'b0;

    if (stop) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (arm) begin
            next_state       = ARMED;
            load_cfg         = 1'b1;
            pulse_count_next = '0;
          end
        end
        ARMED: begin
          if (trig_edge) begin
            if (cfg_delay == '0) begin
              next_state       = PULSE;
              wcnt_next        = cfg_width - WIDTH_W'(1);
              pulse_count_next = pulse_count + REP_W'(1);
            end else begin
              next_state = DELAY;
              cnt_next   = cfg_delay - DELAY_W'(1);
            end
          end
        end
        DELAY, GAP: begin
          if (cnt == '0) begin
            next_state       = PULSE;
            wcnt_next        = cfg_width - WIDTH_W'(1);
            pulse_count_next = pulse_count + REP_W'(1);
          end else begin
            cnt_next = cnt - DELAY_W'(1);
          end
        end
        PULSE: begin
          if (wcnt == '0) begin
            if (pulse_count < cfg_repeat) begin
              next_state = GAP;
              cnt_next   = cfg_gap - DELAY_W'(1);
            end else begin
              next_state = IDLE;
              done_next  = 1'b1;
            end
          end else begin
            wcnt_next = wcnt - WIDTH_W'(1);
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered so they align with the state.
  always_comb begin
    glitch_en_next = (next_state == PULSE);
    armed_next     = (next_state == ARMED);
    busy_next      = (next_state != IDLE);
  end

endmodule

// File: tb/tb_glitch_trigger_ctrl.sv
// Randomized scoreboard bench for glitch_trigger_ctrl: expected pulses and done events are
// derived from the arm/trigger/abort timeline and compared by an independent monitor.
module tb_glitch_trigger_ctrl;
  import glitch_pkg::*;

  localparam int DW   = DEF_DELAY_W;
  localparam int WW   = DEF_WIDTH_W;
  localparam int RW   = DEF_REP_W;
  localparam int SYNC = DEF_SYNC_STAGES;
  localparam int NEVER = 32'h7fff_ffff;

  logic          clk = 1'b0;
  logic          reset, arm, abort, pll_relock, trigger_in;
  logic [DW-1:0] delay_cycles, gap_cycles;
  logic [WW-1:0] width_cycles;
  logic [RW-1:0] repeat_count;
  logic          glitch_en, armed, busy, done;
  logic [RW-1:0] pulse_count;

  glitch_trigger_ctrl #(
    .DELAY_W     (DW),
    .WIDTH_W     (WW),
    .REP_W       (RW),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .abort        (abort),
    .pll_relock   (pll_relock),
    .trigger_in   (trigger_in),
    .delay_cycles (delay_cycles),
    .width_cycles (width_cycles),
    .gap_cycles   (gap_cycles),
    .repeat_count (repeat_count),
    .glitch_en    (glitch_en),
    .armed        (armed),
    .busy         (busy),
    .done         (done),
    .pulse_count  (pulse_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int start; int width; } pulse_t;
  typedef struct { int at; int count; } done_t;
  pulse_t pulse_q[$];
  done_t  done_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: measures each glitch_en pulse and each done pulse and pops the matching expectation.
  initial begin
    bit     prev = 1'b0;
    int     st = 0;
    pulse_t pe;
    done_t  de;
    forever begin
      @(negedge clk);
      if (glitch_en === 1'b1 && !prev) st = cyc;
      if (glitch_en !== 1'b1 && prev) begin
        if (pulse_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pulse: start %0d width %0d, expected no pulse", st, cyc - st);
        end else begin
          pe = pulse_q.pop_front();
          check("pulse_start", st, pe.start);
          check("pulse_width", cyc - st, pe.width);
        end
      end
      prev = (glitch_en === 1'b1);
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done at cycle %0d, expected no done", cyc);
        end else begin
          de = done_q.pop_front();
          check("done_cycle", cyc, de.at);
          check("done_pulse_count", pulse_count, de.count);
        end
      end
    end
  end

  // One arm/trigger run. kind: 0 none, 1 abort, 2 pll_relock, 3 reset, applied in cycle p+abort_off.
  task automatic run(input int d, input int w, input int g, input int r,
                     input int kind, input int abort_off, input bit noise);
    int we, ge, re, p, start0, ac, done_at, end_at, started, st;
    we = (w == 0) ? 1 : w;
    ge = (g == 0) ? 1 : g;
    re = (r == 0) ? 1 : r;

    trigger_in = 1'b0;
    arm = 1'b0;
    repeat (SYNC + 3) step();

    delay_cycles = DW'(d);
    width_cycles = WW'(w);
    gap_cycles   = DW'(g);
    repeat_count = RW'(r);
    arm = 1'b1;
    step();
    arm = 1'b0;
    check("armed_after_arm", armed, 1);
    check("busy_after_arm", busy, 1);
    check("pulse_count_cleared", pulse_count, 0);
    delay_cycles = DW'($urandom);
    width_cycles = WW'($urandom);
    gap_cycles   = DW'($urandom);
    repeat_count = RW'($urandom);
    repeat (2) step();

    // Pin rises in cycle p; edge seen in cycle p+SYNC; first pulse at edge+1+delay.
    p = cyc;
    trigger_in = 1'b1;
    start0  = p + SYNC + 1 + d;
    ac      = (kind == 0) ? NEVER : p + abort_off;
    done_at = start0 + (re - 1) * (we + ge) + we;
    started = 0;
    for (int i = 0; i < re; i++) begin
      pulse_t e;
      st = start0 + i * (we + ge);
      if (st <= ac) begin
        e.start = st;
        e.width = (we < ac - st + 1) ? we : ac - st + 1;
        pulse_q.push_back(e);
        started++;
      end
    end
    if (done_at <= ac) begin
      done_t e;
      e.at    = done_at;
      e.count = re;
      done_q.push_back(e);
    end
    end_at = ((ac < done_at) ? ac : done_at) + 3;

    while (cyc < end_at) begin
      arm        = noise && (cyc == p + 1);
      abort      = (kind == 1) && (cyc == ac);
      pll_relock = (kind == 2) && (cyc == ac);
      reset      = (kind == 3) && (cyc == ac);
      if (noise && cyc == p + 3) trigger_in = 1'b0;
      if (noise && cyc == p + 7) trigger_in = 1'b1;
      step();
      if (kind != 0 && cyc == ac + 1) begin
        check("stop_glitch_en", glitch_en, 0);
        check("stop_armed", armed, 0);
        check("stop_busy", busy, 0);
        check("stop_done", done, 0);
      end
    end
    arm = 1'b0;
    abort = 1'b0;
    pll_relock = 1'b0;
    reset = 1'b0;
    check("busy_at_end", busy, 0);
    check("pulse_count_at_end", pulse_count, (kind == 3) ? 0 : started);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d, w, g, r, we, ge, re, kind, aoff;
    reset = 1'b1;
    arm = 1'b0;
    abort = 1'b0;
    pll_relock = 1'b0;
    trigger_in = 1'b0;
    delay_cycles = '0;
    width_cycles = '0;
    gap_cycles = '0;
    repeat_count = '0;
    repeat (3) step();
    check("reset_glitch_en", glitch_en, 0);
    check("reset_armed", armed, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_pulse_count", pulse_count, 0);
    reset = 1'b0;
    step();

    run(0, 1, 0, 1, 0, 0, 1'b0);
    run(10, 3, 2, 3, 0, 0, 1'b0);
    run($urandom_range(0, 5), 0, 0, 0, 0, 0, 1'b0);

    // Edge before arm must not be remembered.
    trigger_in = 1'b0;
    repeat (5) step();
    trigger_in = 1'b1;
    repeat (SYNC + 4) step();
    arm = 1'b1;
    step();
    arm = 1'b0;
    repeat (20) step();
    check("stale_edge_armed", armed, 1);
    check("stale_edge_glitch_en", glitch_en, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_armed", armed, 0);
    check("abort_busy", busy, 0);

    // arm and abort together in IDLE stay IDLE.
    arm = 1'b1;
    abort = 1'b1;
    step();
    arm = 1'b0;
    abort = 1'b0;
    check("arm_abort_busy", busy, 0);
    check("arm_abort_armed", armed, 0);

    run(2, 8, 1, 1, 2, SYNC + 1 + 2 + 3, 1'b0);
    run(15, 2, 1, 1, 3, SYNC + 1 + 5, 1'b0);
    run(3, 2, 2, 2, 0, 0, 1'b0);

    for (int n = 0; n < 14; n++) begin
      d = $urandom_range(0, 20);
      w = $urandom_range(0, 6);
      g = $urandom_range(0, 5);
      r = $urandom_range(0, 4);
      we = (w == 0) ? 1 : w;
      ge = (g == 0) ? 1 : g;
      re = (r == 0) ? 1 : r;
      kind = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      aoff = $urandom_range(SYNC + 1, SYNC + 1 + d + re * (we + ge));
      run(d, w, g, r, kind, aoff, 1'($urandom_range(0, 1)));
    end

    repeat (5) step();
    check("pulse_queue_drained", pulse_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
